// File: rtl/wor_arb_node.sv
// wor_arb_node: bus node on a shared single-wire wired-OR line.
// Arbitrates bit-wise with its node ID (a 1 dominates, so the highest ID wins),
// sends one data word when it wins and receives every frame on the line.
// Frame: start bit 1, ID_W ID bits MSB-first, DATA_W data bits MSB-first, one 0 gap cycle.
// Optional feature: define WOR_COLLISION_CHECK_EN to detect same-ID collisions
// during DATA; the winner then pulses err instead of done.
module wor_arb_node #(
  parameter int unsigned       ID_W    = 4,
  parameter int unsigned       DATA_W  = 8,
  parameter logic [ID_W-1:0]   NODE_ID = ID_W'(1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [DATA_W-1:0] data_in,
  output logic              bus_drv,
  input  logic              bus_in,
  output logic              busy,
  output logic              grant,
  output logic              lost,
  output logic              done,
  output logic              err,
  output logic [ID_W-1:0]   rx_id,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid
);

  localparam int unsigned FRAME_LEN = 1 + ID_W + DATA_W;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int unsigned TX_W      = ID_W + DATA_W;

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_START,
    S_ARB,
    S_DATA,
    S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TX_W-1:0]     tx_q, tx_d;
  logic                contend_q, contend_d;
  logic                bus_drv_q, bus_drv_d;
  logic                lost_q, lost_d;
  logic                done_q, done_d;
  logic                rx_valid_q, rx_valid_d;
  logic [ID_W-1:0]     id_sh_q, id_sh_d;
  logic [DATA_W-1:0]   dat_sh_q, dat_sh_d;
  logic [ID_W-1:0]     rx_id_q, rx_id_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                last_bit;
`ifdef WOR_COLLISION_CHECK_EN
  logic                coll_q, coll_d;
  logic                err_q, err_d;
`endif

  // Bit counter value loaded on entry to each state
  function automatic logic [CNT_W-1:0] load_cnt(input state_e s);
    case (s)
      S_SYNC:  load_cnt = CNT_W'(FRAME_LEN - 1);
      S_ARB:   load_cnt = CNT_W'(ID_W - 1);
      S_DATA:  load_cnt = CNT_W'(DATA_W - 1);
      default: load_cnt = '0;
    endcase
  endfunction

  assign last_bit = (cnt_q == '0);

  // State and datapath registers; reset forces SYNC and releases the line at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_SYNC;
      cnt_q      <= CNT_W'(FRAME_LEN - 1);
      tx_q       <= '0;
      contend_q  <= 1'b0;
      bus_drv_q  <= 1'b0;
      lost_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      id_sh_q    <= '0;
      dat_sh_q   <= '0;
      rx_id_q    <= '0;
      rx_data_q  <= '0;
`ifdef WOR_COLLISION_CHECK_EN
      coll_q     <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      contend_q  <= contend_d;
      bus_drv_q  <= bus_drv_d;
      lost_q     <= lost_d;
      done_q     <= done_d;
      rx_valid_q <= rx_valid_d;
      id_sh_q    <= id_sh_d;
      dat_sh_q   <= dat_sh_d;
      rx_id_q    <= rx_id_d;
      rx_data_q  <= rx_data_d;
`ifdef WOR_COLLISION_CHECK_EN
      coll_q     <= coll_d;
      err_q      <= err_d;
`endif
    end
  end

  // Next-state: frame position is tracked purely by the bit counter
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SYNC:  if (!bus_in && last_bit) state_d = S_IDLE;
      S_IDLE: begin
        if (!bus_in && req) state_d = S_START;
        else if (bus_in)    state_d = S_ARB;
      end
      S_START: state_d = S_ARB;
      S_ARB:   if (last_bit) state_d = S_DATA;
      S_DATA:  if (last_bit) state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_SYNC;
    endcase
  end

  // Datapath: counter, transmit shifter, arbitration, receive shifters, pulses
  always_comb begin
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    contend_d  = contend_q;
    bus_drv_d  = bus_drv_q;
    lost_d     = 1'b0;
    done_d     = 1'b0;
    rx_valid_d = 1'b0;
    id_sh_d    = id_sh_q;
    dat_sh_d   = dat_sh_q;
    rx_id_d    = rx_id_q;
    rx_data_d  = rx_data_q;
`ifdef WOR_COLLISION_CHECK_EN
    coll_d     = coll_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      S_SYNC: begin
        bus_drv_d = 1'b0;
        contend_d = 1'b0;
        if (bus_in)         cnt_d = CNT_W'(FRAME_LEN - 1);
        else if (!last_bit) cnt_d = cnt_q - 1'b1;
      end
      S_IDLE: begin
        bus_drv_d = 1'b0;
        contend_d = 1'b0;
`ifdef WOR_COLLISION_CHECK_EN
        coll_d    = 1'b0;
`endif
        if (!bus_in && req) begin
          tx_d      = {NODE_ID, data_in};
          contend_d = 1'b1;
          bus_drv_d = 1'b1;
        end
      end
      S_START: begin
        bus_drv_d = tx_q[TX_W-1];
        tx_d      = tx_q << 1;
      end
      S_ARB: begin
        id_sh_d = ID_W'({id_sh_q, bus_in});
        if (!last_bit) cnt_d = cnt_q - 1'b1;
        if (contend_q) begin
          if (!bus_drv_q && bus_in) begin
            contend_d = 1'b0;
            lost_d    = 1'b1;
            bus_drv_d = 1'b0;
          end else begin
            // After the last ID bit the shifter MSB is already the data MSB
            bus_drv_d = tx_q[TX_W-1];
            tx_d      = tx_q << 1;
          end
        end else begin
          bus_drv_d = 1'b0;
        end
      end
      S_DATA: begin
        dat_sh_d = DATA_W'({dat_sh_q, bus_in});
`ifdef WOR_COLLISION_CHECK_EN
        if (contend_q && (bus_in != bus_drv_q)) coll_d = 1'b1;
`endif
        if (!last_bit) begin
          cnt_d = cnt_q - 1'b1;
          if (contend_q) begin
            bus_drv_d = tx_q[TX_W-1];
            tx_d      = tx_q << 1;
          end
        end else begin
          bus_drv_d  = 1'b0;
          rx_valid_d = 1'b1;
          rx_id_d    = id_sh_q;
          rx_data_d  = dat_sh_d;
`ifdef WOR_COLLISION_CHECK_EN
          done_d     = contend_q & ~coll_d;
          err_d      = contend_q & coll_d;
`else
          done_d     = contend_q;
`endif
        end
      end
      S_GAP: begin
        bus_drv_d = 1'b0;
        contend_d = 1'b0;
      end
      default: begin
        bus_drv_d = 1'b0;
        contend_d = 1'b0;
      end
    endcase
    if (state_d != state_q) cnt_d = load_cnt(state_d);
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy  = (state_q != S_IDLE);
    grant = (state_q == S_DATA) && contend_q;
  end

  assign bus_drv  = bus_drv_q;
  assign lost     = lost_q;
  assign done     = done_q;
  assign rx_valid = rx_valid_q;
  assign rx_id    = rx_id_q;
  assign rx_data  = rx_data_q;
`ifdef WOR_COLLISION_CHECK_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_wor_arb_node.sv
// Bench for wor_arb_node: four nodes (IDs 5, 9, 3, 9) on one wired-OR line.
// Expected receive/done/err/lost events are queued as stimulus is issued; a
// negedge monitor pops and compares them whenever a node pulses.
module tb_wor_arb_node;

  localparam int K_RX   = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;
  localparam int K_LOST = 3;
  localparam logic [3:0] IDS [4] = '{4'd5, 4'd9, 4'd3, 4'd9};

`ifdef WOR_COLLISION_CHECK_EN
  localparam int K_COLL = K_ERR;
`else
  localparam int K_COLL = K_DONE;
`endif

  typedef struct {
    int          node;
    int          kind;
    logic [11:0] val;
  } exp_t;

  logic       clk;
  logic [3:0] rstn, req, busy, grant, drv, rxv, dn, er, ls;
  logic [7:0] din  [4];
  logic [3:0] rid  [4];
  logic [7:0] rdat [4];
  logic       bus;
  logic       mon_en;
  logic [3:0] hit;

  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];

  assign bus = |drv;

  for (genvar g = 0; g < 4; g++) begin : g_node
    wor_arb_node #(
      .ID_W    (4),
      .DATA_W  (8),
      .NODE_ID (IDS[g])
    ) u_node (
      .clk      (clk),
      .rst_n    (rstn[g]),
      .req      (req[g]),
      .data_in  (din[g]),
      .bus_drv  (drv[g]),
      .bus_in   (bus),
      .busy     (busy[g]),
      .grant    (grant[g]),
      .lost     (ls[g]),
      .done     (dn[g]),
      .err      (er[g]),
      .rx_id    (rid[g]),
      .rx_data  (rdat[g]),
      .rx_valid (rxv[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_ev(input int n, input int k, input logic [11:0] v);
    sbq.push_back('{node: n, kind: k, val: v});
  endtask

  task automatic sb_match(input int n, input int k, input logic [11:0] v);
    int idx;
    idx = -1;
    foreach (sbq[i]) if (idx < 0 && sbq[i].node == n && sbq[i].kind == k) idx = i;
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected_event node%0d kind%0d: got pulse, expected none", n, k);
    end else begin
      if (k == K_RX && v !== sbq[idx].val) begin
        errors++;
        $display("FAIL rx_frame node%0d: got %h, expected %h", n, v, sbq[idx].val);
      end
      sbq.delete(idx);
    end
  endtask

  // Monitor: every output pulse must match a queued expectation
  always @(negedge clk) begin
    if (mon_en) begin
      for (int n = 0; n < 4; n++) begin
        hit = {ls[n], er[n], dn[n], rxv[n]};
        for (int k = 0; k < 4; k++)
          if (hit[k]) sb_match(n, k, {rid[n], rdat[n]});
      end
    end
  end

  initial begin
    logic [15:0] pat;
    int          gcnt;
    int          cnt;
    logic        bus_seen;

    mon_en = 1'b0;
    req    = '0;
    for (int n = 0; n < 4; n++) din[n] = '0;
    rstn   = '1;
    #1 rstn = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 4'hF);
    chk("rst_drv", drv, 4'h0);
    chk("rst_pulses", {rxv, dn, er, ls, grant}, 20'h0);
    for (int n = 0; n < 4; n++) chk("rst_rx", {rid[n], rdat[n]}, 12'h000);

    // Quiet bus: 13 zero samples then IDLE
    rstn   = '1;
    mon_en = 1'b1;
    cnt = 0;
    bus_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      bus_seen |= bus;
      if (!busy[0]) break;
    end
    chk("sync_edges", cnt, 13);
    chk("sync_all_idle", busy, 4'h0);
    chk("sync_bus_quiet", bus_seen, 0);

    // Node 5 sends 0xA5
    req[0] = 1'b1;
    din[0] = 8'hA5;
    for (int n = 0; n < 4; n++) expect_ev(n, K_RX, 12'h5A5);
    expect_ev(0, K_DONE, 12'h0);
    pat = '0;
    gcnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      pat = {pat[14:0], bus};
      gcnt += int'(grant[0]);
      if (i == 0) req[0] = 1'b0;
    end
    chk("frame_a5_bits", pat[13:0], 14'b1_0101_10100101_0);
    chk("grant_cycles", gcnt, 8);

    // Nodes 5 and 9 contend; node 3 requests mid-frame and follows after GAP+IDLE
    @(negedge clk);
    req[0] = 1'b1; din[0] = 8'h11;
    req[1] = 1'b1; din[1] = 8'h3C;
    for (int n = 0; n < 4; n++) expect_ev(n, K_RX, 12'h93C);
    expect_ev(0, K_LOST, 12'h0);
    expect_ev(1, K_DONE, 12'h0);
    pat = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pat = {pat[14:0], bus};
      if (i == 0) begin
        req[0] = 1'b0;
        req[1] = 1'b0;
      end
      if (i == 2) chk("lost_first_id_bit", ls[0], 1);
      if (i == 4) begin
        req[2] = 1'b1;
        din[2] = 8'h5A;
        for (int n = 0; n < 4; n++) expect_ev(n, K_RX, 12'h35A);
        expect_ev(2, K_DONE, 12'h0);
      end
      if (i == 15) req[2] = 1'b0;
    end
    chk("frame_9_then_start3", pat, 16'b1_1001_00111100_0_0_1);
    repeat (14) @(negedge clk);

    // Node 5 reset during its DATA phase
    req[0] = 1'b1;
    din[0] = 8'hFF;
    for (int n = 1; n < 4; n++) expect_ev(n, K_RX, 12'h5C0);
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      if (j == 0) req[0] = 1'b0;
      if (j == 7) begin
        chk("drv_before_rst", drv[0], 1);
        rstn[0] = 1'b0;
        #1 chk("drv_async_rst", drv[0], 0);
      end
      if (j == 8) rstn[0] = 1'b1;
    end
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (!busy[0]) break;
    end
    chk("resync_edges", cnt, 13);

    // Two ID-9 nodes collide in DATA
    chk("idle_before_coll", busy, 4'h0);
    req[1] = 1'b1; din[1] = 8'h0F;
    req[3] = 1'b1; din[3] = 8'hF0;
    for (int n = 0; n < 4; n++) expect_ev(n, K_RX, 12'h9FF);
    expect_ev(1, K_COLL, 12'h0);
    expect_ev(3, K_COLL, 12'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req[1] = 1'b0;
        req[3] = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    chk("missing_events", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
